// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, and an iterative multiply/divide
// unit that owns HI/LO. ALU outputs are combinational; mult/div takes
// one start cycle plus MD_CYCLES step cycles.
module execute_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  alu_op_e_i,
    input  logic        alu_src_e_i,
    input  logic        shift_var_e_i,
    input  logic        reg_dst_e_i,
    input  logic [2:0]  md_op_e_i,
    input  logic        lo_sel_e_i,
    input  logic [31:0] reg_data_1_e_i,
    input  logic [31:0] reg_data_2_e_i,
    input  logic [4:0]  rt_e_i,
    input  logic [4:0]  rd_e_i,
    input  logic [4:0]  shamt_e_i,
    input  logic [31:0] ext_imm_e_i,
    input  logic [1:0]  forward_a_e_i,
    input  logic [1:0]  forward_b_e_i,
    input  logic [31:0] alu_out_m_i,
    input  logic [31:0] result_w_i,
    output logic [31:0] alu_out_e_o,
    output logic [31:0] write_data_e_o,
    output logic [4:0]  write_reg_e_o,
    output logic        md_busy_o
);
    localparam int CW = $clog2(MD_CYCLES) + 1;

    typedef enum logic {IDLE, RUN} md_state_t;

    md_state_t   state, state_next;
    logic [CW-1:0] cnt;
    logic [31:0] hi, lo;
    logic [63:0] p, p_step;
    logic [31:0] op_b, dividend;
    logic        op_div, sign_q, sign_r, div_zero;
    logic        md_start, md_done;

    logic [31:0] src_a, fwd_b, src_b, alu_res;
    logic [4:0]  sh;

    // Operand forwarding and immediate select
    always_comb begin
        case (forward_a_e_i)
            2'b01:   src_a = result_w_i;
            2'b10:   src_a = alu_out_m_i;
            default: src_a = reg_data_1_e_i;
        endcase
        case (forward_b_e_i)
            2'b01:   fwd_b = result_w_i;
            2'b10:   fwd_b = alu_out_m_i;
            default: fwd_b = reg_data_2_e_i;
        endcase
        src_b = alu_src_e_i ? ext_imm_e_i : fwd_b;
        sh    = shift_var_e_i ? src_a[4:0] : shamt_e_i;
    end

    // ALU function decode; unused encodings yield zero
    always_comb begin
        alu_res = 32'd0;
        case (alu_op_e_i)
            4'h0: alu_res = src_a + src_b;
            4'h1: alu_res = src_a - src_b;
            4'h2: alu_res = src_a & src_b;
            4'h3: alu_res = src_a | src_b;
            4'h4: alu_res = src_a ^ src_b;
            4'h5: alu_res = ~(src_a | src_b);
            4'h6: alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
            4'h7: alu_res = {31'd0, src_a < src_b};
            4'h8: alu_res = src_b << sh;
            4'h9: alu_res = src_b >> sh;
            4'hA: alu_res = $unsigned($signed(src_b) >>> sh);
            4'hB: alu_res = {src_b[15:0], 16'd0};
            default: alu_res = 32'd0;
        endcase
    end

    // Result/destination muxing; MFHI/MFLO override the ALU
    always_comb begin
        case (md_op_e_i)
            3'd5:    alu_out_e_o = hi;
            3'd6:    alu_out_e_o = lo;
            default: alu_out_e_o = alu_res;
        endcase
        write_data_e_o = fwd_b;
        write_reg_e_o  = reg_dst_e_i ? rd_e_i : rt_e_i;
    end

    // Mult/div state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // Mult/div next state and start/done strobes
    always_comb begin
        state_next = state;
        md_start   = 1'b0;
        md_done    = 1'b0;
        case (state)
            IDLE: if (md_op_e_i >= 3'd1 && md_op_e_i <= 3'd4) begin
                md_start   = 1'b1;
                state_next = RUN;
            end
            RUN: if (cnt == CW'(MD_CYCLES - 1)) begin
                md_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign md_busy_o = md_start | (state == RUN);

    // One iteration: shift-add multiply, or restoring divide where
    // p holds {remainder, quotient-being-built}
    logic [32:0] sum, rem_sh, diff;
    always_comb begin
        sum    = {1'b0, p[63:32]} + (p[0] ? {1'b0, op_b} : 33'd0);
        rem_sh = {p[63:32], p[31]};
        diff   = rem_sh - {1'b0, op_b};
        if (op_div)
            p_step = diff[32] ? {rem_sh[31:0], p[30:0], 1'b0}
                              : {diff[31:0],   p[30:0], 1'b1};
        else
            p_step = {sum, p[31:1]};
    end

    // Operand magnitudes and result signs taken at the start edge
    logic        is_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod_neg;
    always_comb begin
        is_signed = (md_op_e_i == 3'd1) || (md_op_e_i == 3'd3);
        a_neg     = is_signed & src_a[31];
        b_neg     = is_signed & fwd_b[31];
        a_mag     = a_neg ? -src_a : src_a;
        b_mag     = b_neg ? -fwd_b : fwd_b;
        prod_neg  = -p_step;
    end

    // Mult/div datapath, HI/LO and moves into HI/LO
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0; hi <= '0; lo <= '0; p <= '0;
            op_b <= '0; dividend <= '0;
            op_div <= 1'b0; sign_q <= 1'b0; sign_r <= 1'b0; div_zero <= 1'b0;
        end else if (md_start) begin
            cnt      <= '0;
            p        <= {32'd0, a_mag};
            op_b     <= b_mag;
            dividend <= src_a;
            op_div   <= (md_op_e_i == 3'd3) || (md_op_e_i == 3'd4);
            sign_q   <= a_neg ^ b_neg;
            sign_r   <= a_neg;
            div_zero <= (fwd_b == 32'd0);
        end else if (state == RUN) begin
            p   <= p_step;
            cnt <= md_done ? '0 : cnt + CW'(1);
            if (md_done) begin
                if (!op_div) begin
                    {hi, lo} <= sign_q ? prod_neg : p_step;
                end else if (div_zero) begin
                    lo <= 32'hFFFF_FFFF;
                    hi <= dividend;
                end else begin
                    lo <= sign_q ? -p_step[31:0]  : p_step[31:0];
                    hi <= sign_r ? -p_step[63:32] : p_step[63:32];
                end
            end
        end else if (md_op_e_i == 3'd7) begin
            if (lo_sel_e_i) lo <= src_a;
            else            hi <= src_a;
        end
    end

    // Reading HI/LO mid-operation means the hazard unit failed to stall
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(state == RUN && (md_op_e_i == 3'd5 || md_op_e_i == 3'd6)));

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU vector table plus mult/div,
// reset and HI/LO move sequences.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_op;
    logic        alu_src, shift_var, reg_dst, lo_sel;
    logic [2:0]  md_op;
    logic [31:0] rd1, rd2, imm, alu_m, res_w;
    logic [4:0]  rt, rd, shamt;
    logic [1:0]  fa, fb;
    logic [31:0] alu_out, wdata;
    logic [4:0]  wreg;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_stage #(.MD_CYCLES(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .alu_op_e_i(alu_op), .alu_src_e_i(alu_src), .shift_var_e_i(shift_var),
        .reg_dst_e_i(reg_dst), .md_op_e_i(md_op), .lo_sel_e_i(lo_sel),
        .reg_data_1_e_i(rd1), .reg_data_2_e_i(rd2),
        .rt_e_i(rt), .rd_e_i(rd), .shamt_e_i(shamt), .ext_imm_e_i(imm),
        .forward_a_e_i(fa), .forward_b_e_i(fb),
        .alu_out_m_i(alu_m), .result_w_i(res_w),
        .alu_out_e_o(alu_out), .write_data_e_o(wdata), .write_reg_e_o(wreg),
        .md_busy_o(busy)
    );

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic        src;
        logic        sv;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  sh;
        logic [31:0] e_alu;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue a mult/div op and count busy cycles; optionally re-issue a
    // different MULT mid-run at busy cycle `intr`
    task automatic md_run(input string nm, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int intr);
        int n;
        n = 0;
        fa = 2'b00; fb = 2'b00;
        md_op = op; rd1 = a; rd2 = b;
        #1;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
            if (n == intr) begin md_op = 3'd1; rd1 = 32'd99; rd2 = 32'd99; end
            else md_op = 3'd0;
            #1;
        end
        md_op = 3'd0;
        chk({nm, " busy cycles"}, 32'(n), 32'd33);
    endtask

    task automatic read_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
        md_op = 3'd5; #1; chk({nm, " HI"}, alu_out, eh);
        md_op = 3'd6; #1; chk({nm, " LO"}, alu_out, el);
        md_op = 3'd0; #1;
    endtask

    initial begin
        rst = 1'b1; alu_op = 4'h0; alu_src = 1'b0; shift_var = 1'b0; reg_dst = 1'b0;
        lo_sel = 1'b0; md_op = 3'd0; rd1 = '0; rd2 = '0; imm = '0;
        alu_m = 32'd10; res_w = 32'd20; rt = 5'd3; rd = 5'd7; shamt = '0;
        fa = 2'b00; fb = 2'b00;

        vecs[0]  = '{"fwd A=M B=W",  4'h0, 0, 0, 2'b10, 2'b01, 32'd1, 32'd5, 32'd0, 5'd0, 32'd30, 32'd20};
        vecs[1]  = '{"fwd A=M B=reg",4'h0, 0, 0, 2'b10, 2'b00, 32'd1, 32'd5, 32'd0, 5'd0, 32'd15, 32'd5};
        vecs[2]  = '{"fwd A=W B=11", 4'h0, 0, 0, 2'b01, 2'b11, 32'd1, 32'd5, 32'd0, 5'd0, 32'd25, 32'd5};
        vecs[3]  = '{"sub",          4'h1, 0, 0, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 5'd0, 32'hFFFFFFFE, 32'd7};
        vecs[4]  = '{"and",          4'h2, 0, 0, 2'b00, 2'b00, 32'hF0F0, 32'hFF00, 32'd0, 5'd0, 32'hF000, 32'hFF00};
        vecs[5]  = '{"or",           4'h3, 0, 0, 2'b00, 2'b00, 32'hF0F0, 32'hFF00, 32'd0, 5'd0, 32'hFFF0, 32'hFF00};
        vecs[6]  = '{"xor",          4'h4, 0, 0, 2'b00, 2'b00, 32'hF0F0, 32'hFF00, 32'd0, 5'd0, 32'h0FF0, 32'hFF00};
        vecs[7]  = '{"nor",          4'h5, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 5'd0, 32'hFFFFFFFF, 32'h0};
        vecs[8]  = '{"slt",          4'h6, 0, 0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd0, 32'd1, 32'd1};
        vecs[9]  = '{"sltu",         4'h7, 0, 0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd0, 32'd0, 32'd1};
        vecs[10] = '{"sra",          4'hA, 0, 0, 2'b00, 2'b00, 32'd0, 32'h80000000, 32'd0, 5'd4, 32'hF8000000, 32'h80000000};
        vecs[11] = '{"srl",          4'h9, 0, 0, 2'b00, 2'b00, 32'd0, 32'h80000000, 32'd0, 5'd4, 32'h08000000, 32'h80000000};
        vecs[12] = '{"sllv",         4'h8, 0, 1, 2'b00, 2'b00, 32'd31, 32'd1, 32'd0, 5'd2, 32'h80000000, 32'd1};
        vecs[13] = '{"lui",          4'hB, 1, 0, 2'b00, 2'b00, 32'd0, 32'd3, 32'h0000ABCD, 5'd0, 32'hABCD0000, 32'd3};
        vecs[14] = '{"addi wrap",    4'h0, 1, 0, 2'b00, 2'b00, 32'd1, 32'd3, 32'hFFFFFFFF, 5'd0, 32'd0, 32'd3};
        vecs[15] = '{"bad op",       4'hF, 0, 0, 2'b00, 2'b00, 32'd5, 32'd6, 32'd0, 5'd0, 32'd0, 32'd6};

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        read_hilo("reset", 32'd0, 32'd0);

        // ALU table
        for (int i = 0; i < 16; i++) begin
            alu_op = vecs[i].op; alu_src = vecs[i].src; shift_var = vecs[i].sv;
            fa = vecs[i].fa; fb = vecs[i].fb; rd1 = vecs[i].r1; rd2 = vecs[i].r2;
            imm = vecs[i].imm; shamt = vecs[i].sh;
            #1;
            chk({vecs[i].nm, " alu"}, alu_out, vecs[i].e_alu);
            chk({vecs[i].nm, " wdata"}, wdata, vecs[i].e_wd);
        end
        alu_op = 4'h0; alu_src = 1'b0; shift_var = 1'b0; fa = 2'b00; fb = 2'b00;

        reg_dst = 1'b1; #1; chk("wreg rd", {27'd0, wreg}, 32'd7);
        reg_dst = 1'b0; #1; chk("wreg rt", {27'd0, wreg}, 32'd3);

        // Mult/div results
        @(posedge clk); #1;
        md_run("mult -3x5", 3'd1, 32'hFFFFFFFD, 32'd5, -10);
        read_hilo("mult -3x5", 32'hFFFFFFFF, 32'hFFFFFFF1);
        md_run("multu", 3'd2, 32'hFFFFFFFF, 32'd2, -10);
        read_hilo("multu", 32'd1, 32'hFFFFFFFE);
        md_run("divu 100/7", 3'd4, 32'd100, 32'd7, -10);
        read_hilo("divu 100/7", 32'd2, 32'd14);
        md_run("div -7/2", 3'd3, 32'hFFFFFFF9, 32'd2, -10);
        read_hilo("div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD);
        md_run("div min/-1", 3'd3, 32'h80000000, 32'hFFFFFFFF, -10);
        read_hilo("div min/-1", 32'd0, 32'h80000000);
        md_run("div 9/0", 3'd3, 32'd9, 32'd0, -10);
        read_hilo("div 9/0", 32'd9, 32'hFFFFFFFF);

        // Reset mid-operation discards the partial product
        md_op = 3'd1; rd1 = 32'd6; rd2 = 32'd7;
        @(posedge clk); #1; md_op = 3'd0;
        repeat (9) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; #1;
        chk("mid-reset busy", {31'd0, busy}, 32'd0);
        read_hilo("mid-reset", 32'd0, 32'd0);
        md_run("mult after reset", 3'd1, 32'd6, 32'd7, -10);
        read_hilo("mult after reset", 32'd0, 32'd42);

        // MTLO / MTHI
        md_op = 3'd7; lo_sel = 1'b1; rd1 = 32'h1234;
        @(posedge clk); #1;
        md_op = 3'd7; lo_sel = 1'b0; rd1 = 32'h5678;
        @(posedge clk); #1; md_op = 3'd0; lo_sel = 1'b0;
        read_hilo("mthi/mtlo", 32'h5678, 32'h1234);

        // MULT issued during RUN must not restart or corrupt the result
        md_run("mult with intruder", 3'd1, 32'hFFFFFFFD, 32'd5, 5);
        read_hilo("mult with intruder", 32'hFFFFFFFF, 32'hFFFFFFF1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
